// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Bundles every signal exchanged between the pipeline datapath and the
//   hazard controller.
//   master : the pipeline datapath. It drives the hazard-detection inputs and
//            the memory req/ack pair, and receives the enables and flushes.
//   slave  : pipe_hazard_ctrl.
//
// Handshake: mem_req_valid stays high while the instruction in MEM needs
// memory. The access completes in the cycle in which mem_req_valid and
// mem_ack are both high. mem_ack never has to wait for a controller-side
// ready signal. A request that is still open holds the whole pipeline.
//
// dbg_state exposes the controller FSM encoding (0=RUN, 1=MEM_WAIT, 2=ERROR)
// so that checkers can bind to it.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 4
);
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic              ex_mem_read;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_branch_taken;
  logic              mem_req_valid;
  logic              mem_ack;
  logic              pc_we;
  logic              if_id_we;
  logic              id_ex_we;
  logic              ex_mem_we;
  logic              mem_wb_we;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic              mem_busy;
  logic              mem_timeout_err;
  logic [15:0]       stall_cnt;
  logic [1:0]        dbg_state;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, mem_req_valid, mem_ack,
    input  pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush,
           id_ex_flush, mem_busy, mem_timeout_err, stall_cnt, dbg_state
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
           ex_branch_taken, mem_req_valid, mem_ack,
    output pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, if_id_flush,
           id_ex_flush, mem_busy, mem_timeout_err, stall_cnt, dbg_state
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Sequencing controller for the 16-bit five-stage pipeline. It generates
//   the PC and pipeline-register write enables and the IF/ID and ID/EX
//   flushes. It resolves these conditions in priority order:
//     1. memory wait
//     2. taken branch
//     3. load-use hazard
//   It also counts stalled cycles (pc_we=0), saturating at 0xFFFF.
// Ports:
//   clk   : clock, all state is updated on the rising edge
//   reset : synchronous, active-high
//   bus   : pipe_hazard_ctrl_if.slave, which carries the hazard inputs, the
//           mem req/ack, the enables and flushes, mem_busy, mem_timeout_err,
//           stall_cnt and dbg_state
// The enables and flushes are combinational in the current state and inputs.
// mem_busy, mem_timeout_err, stall_cnt and dbg_state come from flops.
module pipe_hazard_ctrl #(
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.slave   bus
);

  localparam int WCW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           err_q, err_d;
  logic [15:0]    stall_cnt_q, stall_cnt_d;

  logic [REG_AW-1:0] ex_rd;
  logic              load_use;
  logic              mem_stall;
  logic              pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
  logic              if_id_flush, id_ex_flush;

  assign ex_rd = bus.ex_rd;

  // x0 is hard-wired to zero, so a load that targets x0 never creates a
  // dependency.
  assign load_use = bus.ex_mem_read && (ex_rd != '0) &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == ex_rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == ex_rd)));

  assign mem_stall = ((state_q == ST_RUN) && bus.mem_req_valid && !bus.mem_ack) ||
                     ((state_q == ST_MEM_WAIT) && !bus.mem_ack);

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    err_d       = err_q;
    pc_we       = 1'b0;
    if_id_we    = 1'b0;
    id_ex_we    = 1'b0;
    ex_mem_we   = 1'b0;
    mem_wb_we   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;

    if (reset) begin
      state_d    = ST_RUN;
      wait_cnt_d = '0;
      err_d      = 1'b0;
    end else if (state_q == ST_ERROR) begin
      err_d = 1'b1;
    end else if ((state_q != ST_RUN) && (state_q != ST_MEM_WAIT)) begin
      // An unused encoding recovers to RUN with the pipeline frozen.
      state_d    = ST_RUN;
      wait_cnt_d = '0;
    end else if (mem_stall) begin
      // The whole pipeline is frozen. A branch or load-use condition that
      // arrives now is seen again once the access completes.
      if (state_q == ST_RUN) begin
        state_d    = ST_MEM_WAIT;
        wait_cnt_d = WCW'(1);
      end else if (wait_cnt_q == WCW'(MEM_TIMEOUT)) begin
        state_d    = ST_ERROR;
        wait_cnt_d = '0;
        err_d      = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + WCW'(1);
      end
    end else begin
      // This covers normal RUN, a zero-wait access, and the release cycle
      // of MEM_WAIT. In all three the branch and load-use rules apply.
      if (state_q == ST_MEM_WAIT) begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
      pc_we     = 1'b1;
      if_id_we  = 1'b1;
      id_ex_we  = 1'b1;
      ex_mem_we = 1'b1;
      mem_wb_we = 1'b1;
      if (bus.ex_branch_taken) begin
        // The ID instruction is squashed, so its load-use hazard is moot.
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID one cycle. A bubble goes into ID/EX.
        pc_we       = 1'b0;
        if_id_we    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    stall_cnt_d = stall_cnt_q;
    if (reset) begin
      stall_cnt_d = '0;
    end else if (!pc_we && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    wait_cnt_q  <= wait_cnt_d;
    err_q       <= err_d;
    stall_cnt_q <= stall_cnt_d;
  end

  assign bus.pc_we           = pc_we;
  assign bus.if_id_we        = if_id_we;
  assign bus.id_ex_we        = id_ex_we;
  assign bus.ex_mem_we       = ex_mem_we;
  assign bus.mem_wb_we       = mem_wb_we;
  assign bus.if_id_flush     = if_id_flush;
  assign bus.id_ex_flush     = id_ex_flush;
  assign bus.mem_busy        = (state_q == ST_MEM_WAIT);
  assign bus.mem_timeout_err = err_q;
  assign bus.stall_cnt       = stall_cnt_q;
  assign bus.dbg_state       = state_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 16-bit, five-stage core. Each cycle it drives the write enables and flush controls of the PC and the four pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves three conditions, in priority order:
- multi-cycle data-memory accesses, through a req/ack wait FSM with timeout;
- taken-branch squashes;
- load-use hazards.

It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
Parameters:
- REG_AW, 4, register-specifier width
- MEM_TIMEOUT, 15, max MEM_WAIT cycles without ack before error (≥1)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- id_rs1  in  REG_AW  source reg 1 of instruction in ID
- id_rs2  in  REG_AW  source reg 2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  REG_AW  destination reg of instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_req_valid  in  1  instruction in MEM accesses memory (read or write)
- mem_ack  in  1  memory completes the access this cycle
- pc_we  out  1  PC update enable
- if_id_we  out  1  IF/ID load enable
- id_ex_we  out  1  ID/EX load enable
- ex_mem_we  out  1  EX/MEM load enable
- mem_wb_we  out  1  MEM/WB load enable
- if_id_flush  out  1  IF/ID loads zeros (bubble) at next edge
- id_ex_flush  out  1  ID/EX loads zeros (bubble) at next edge
- mem_busy  out  1  FSM in MEM_WAIT
- mem_timeout_err  out  1  sticky memory timeout flag
- stall_cnt  out  16  cycles with pc_we=0, saturating at 0xFFFF

## Operation
FSM states:
- RUN: normal operation.
- MEM_WAIT: waiting for memory acknowledgement.
- ERROR: absorbing until reset.

Internal wait_cnt (width ≥ clog2(MEM_TIMEOUT+1)).

Per-cycle decisions, combinational from state and inputs, highest priority first:
1. **reset=1:** all *_we=0, flushes=0. Next state RUN; wait_cnt=0, stall_cnt=0, mem_timeout_err=0.
2. **ERROR:**
   - all *_we=0, flushes=0, mem_timeout_err=1;
   - stays in ERROR until reset.
3. **Memory stall:**
   - Condition: (RUN and mem_req_valid and !mem_ack) or (MEM_WAIT and !mem_ack).
   - Outputs: all five *_we=0, flushes=0 (whole pipeline frozen; branch/load-use requests are ignored and re-evaluated after release).
   - RUN→MEM_WAIT with wait_cnt=1.
   - In MEM_WAIT: if wait_cnt==MEM_TIMEOUT, go to ERROR; else wait_cnt+1.
4. **Memory release:**
   - Condition: MEM_WAIT and mem_ack.
   - Outputs: all *_we=1, then rules 5–6 apply normally.
   - Next state RUN, wait_cnt=0.
   - A zero-wait access (RUN, mem_req_valid and mem_ack) causes no stall.
5. **Taken branch** (ex_branch_taken):
   - if_id_flush=1, id_ex_flush=1, all *_we=1;
   - load-use check suppressed, since the ID instruction is squashed.
6. **Load-use:**
   - Condition: ex_mem_read and ex_rd≠0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
   - Outputs: pc_we=0, if_id_we=0, id_ex_we=1, id_ex_flush=1, ex_mem_we=1, mem_wb_we=1.
7. **Otherwise:** all *_we=1, flushes=0.

Other outputs and rules:
- stall_cnt increments at each edge where pc_we=0 and reset=0, saturating at 0xFFFF. ERROR cycles count.
- mem_busy=1 exactly when state==MEM_WAIT.
- Register x0 never triggers a load-use stall.

## Timing
- All enables and flushes are combinational (Mealy) and valid in the same cycle as their inputs. The pipeline registers act on the following rising edge.
- Load-use penalty: exactly 1 bubble cycle.
- Taken-branch penalty: 2 squashed slots.
- Memory stall length: (cycle of mem_ack) − (first request cycle). Zero when ack arrives with the request.
- Timeout:
  - With no ack, the request cycle plus MEM_TIMEOUT MEM_WAIT cycles are stalled, then ERROR is entered.
  - mem_timeout_err goes high on the following cycle.
  - An ack in the final MEM_WAIT cycle wins over the timeout.
- Reset mid-MEM_WAIT or in ERROR: RUN at the next edge; outputs follow rule 1 during the reset cycle.
- After reset deasserts, the first cycle is RUN with stall_cnt=0.

## Test plan
- **Load-use:** ex_mem_read=1, ex_rd=3, id_rs2=3, id_uses_rs2=1 → pc_we=0, if_id_we=0, id_ex_flush=1, other *_we=1 for 1 cycle; stall_cnt 0→1. The same case with ex_rd=0 → no stall.
- **Branch vs load-use:** ex_branch_taken=1 together with a load-use match → if_id_flush=1, id_ex_flush=1, pc_we=1, stall_cnt unchanged.
- **Memory wait:** mem_req_valid=1 with mem_ack arriving 3 cycles later → all *_we=0 for 3 cycles, mem_busy=1 for the last 2, release cycle all *_we=1, stall_cnt=3. Zero-wait case (ack with req) → no stall.
- **Priority:** memory stall concurrent with ex_branch_taken=1 → flushes=0 while stalled; flushes asserted in the release cycle.
- **Timeout:** MEM_TIMEOUT=15, mem_ack held 0 → 16 stalled cycles, then ERROR, mem_timeout_err=1 thereafter. Ack on the 16th cycle instead → RUN, no error.
- **Reset in ERROR and mid-wait:** reset=1 for 1 cycle → next cycle state RUN, mem_timeout_err=0, stall_cnt=0, mem_busy=0. Saturation: stall held for 70000 cycles → stall_cnt=0xFFFF.
